// File: rtl/ram_dma.sv
// Block copy/fill engine that masters the single-port RAM, one access per cycle.
// Copies take READ/CAPTURE/WRITE per word; fills write every granted cycle.
module ram_dma #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  fill,
   input  logic [ADDR_WIDTH-1:0] src,
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [DATA_WIDTH-1:0] fill_val,
   input  logic                  abort,
   input  logic                  grant,
   output logic                  mem_enable,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0] mem_di,
   input  logic [DATA_WIDTH-1:0] mem_do,
   output logic                  busy,
   output logic                  done
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] READ    = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] WRITE   = 3'd3;
   localparam logic [2:0] FINISH  = 3'd4;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [DATA_WIDTH-1:0] hold;
   logic                  fill_q;
   logic [DATA_WIDTH-1:0] fill_val_q;
   logic                  abort_q;
   logic                  last_word;

   assign last_word = (remaining == LEN_WIDTH'(1)) || abort || abort_q;

   // An abort seen while not at a granted write is parked in abort_q so the
   // word in flight still completes before the transfer stops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         remaining  <= '0;
         hold       <= '0;
         fill_q     <= 1'b0;
         fill_val_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               abort_q <= 1'b0;
               if (start) begin
                  fill_q     <= fill;
                  fill_val_q <= fill_val;
                  rd_ptr     <= src;
                  wr_ptr     <= dst;
                  remaining  <= len;
                  if (len == '0)
                     state <= FINISH;
                  else if (fill)
                     state <= WRITE;
                  else
                     state <= READ;
               end
            end
            READ: begin
               if (abort)
                  abort_q <= 1'b1;
               if (grant) begin
                  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                  state  <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (abort)
                  abort_q <= 1'b1;
               hold  <= mem_do;
               state <= WRITE;
            end
            WRITE: begin
               if (grant) begin
                  wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
                  remaining <= remaining - LEN_WIDTH'(1);
                  if (last_word)
                     state <= FINISH;
                  else if (!fill_q)
                     state <= READ;
               end else if (abort) begin
                  abort_q <= 1'b1;
               end
            end
            FINISH: begin
               abort_q <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus drive is purely combinational and killed by reset or a missing grant,
   // so nothing reaches the RAM while the engine does not own the port.
   always_comb begin
      mem_enable = 1'b0;
      mem_we     = 1'b0;
      mem_a      = '0;
      mem_di     = '0;
      if (reset && grant) begin
         case (state)
            READ: begin
               mem_enable = 1'b1;
               mem_a      = rd_ptr;
            end
            WRITE: begin
               mem_enable = 1'b1;
               mem_we     = 1'b1;
               mem_a      = wr_ptr;
               mem_di     = fill_q ? fill_val_q : hold;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == READ) || (state == CAPTURE) || (state == WRITE);
   assign done = (state == FINISH);

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: behavioural RAM plus a word-level transfer model that
// predicts the write/read stream, the done cycle and the final memory image.
module tb_ram_dma;

   logic        clk;
   logic        reset;
   logic        start;
   logic        fill;
   logic [15:0] src;
   logic [15:0] dst;
   logic [15:0] len;
   logic [7:0]  fill_val;
   logic        abort;
   logic        grant;
   logic        mem_enable;
   logic        mem_we;
   logic [15:0] mem_a;
   logic [7:0]  mem_di;
   logic [7:0]  mem_do;
   logic        busy;
   logic        done;

   logic        pre_we;
   logic [15:0] pre_a;
   logic [7:0]  pre_d;

   logic [7:0] ram     [0:65535] = '{default: 8'h00};
   logic [7:0] ref_mem [0:65535] = '{default: 8'h00};

   bit gpat [0:1023];
   bit apat [0:1023];
   bit spat [0:1023];

   logic [15:0] exp_wa [$];
   logic [7:0]  exp_wd [$];
   logic [15:0] exp_ra [$];

   int n_vec;
   int n_err;
   int obs_done;

   ram_dma #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .fill(fill), .src(src), .dst(dst),
      .len(len), .fill_val(fill_val), .abort(abort), .grant(grant),
      .mem_enable(mem_enable), .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di),
      .mem_do(mem_do), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with registered read data; the preload port is only used while the engine is idle.
   always @(posedge clk) begin
      if (pre_we)
         ram[pre_a] <= pre_d;
      else if (mem_enable && mem_we)
         ram[mem_a] <= mem_di;
      if (mem_enable && !mem_we)
         mem_do <= ram[mem_a];
      else
         mem_do <= 8'h00;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] v);
      pre_a = a;
      pre_d = v;
      pre_we = 1'b1;
      ref_mem[a] = v;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic clearPatterns();
      for (int k = 0; k < 1024; k++) begin
         gpat[k] = 1'b1;
         apat[k] = 1'b0;
         spat[k] = 1'b0;
      end
   endtask

   task automatic randomPatterns();
      for (int k = 0; k < 1024; k++) begin
         gpat[k] = (k >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
         apat[k] = ($urandom_range(0, 24) == 0);
         spat[k] = ($urandom_range(0, 5) == 0);
      end
   endtask

   // Word-by-word walk over the grant pattern: a copy word waits for a granted
   // read, spends one capture cycle, then waits for a granted write.
   task automatic modelTransfer(input logic f, input logic [15:0] s, input logic [15:0] d,
                                input logic [15:0] l, input logic [7:0] fv, output int dc);
      int t;
      int last_w;
      int n;
      logic ab;
      logic [7:0] w;
      logic [15:0] ra;
      logic [15:0] wa;
      exp_wa.delete();
      exp_wd.delete();
      exp_ra.delete();
      t = 1;
      last_w = 0;
      n = 0;
      ab = 1'b0;
      while (n < int'(l) && !ab) begin
         ra = s + 16'(n);
         wa = d + 16'(n);
         if (!f) begin
            while (!gpat[t]) t++;
            exp_ra.push_back(ra);
            w = ref_mem[ra];
            t += 2;
         end else begin
            w = fv;
         end
         while (!gpat[t]) t++;
         exp_wa.push_back(wa);
         exp_wd.push_back(w);
         ref_mem[wa] = w;
         for (int k = last_w + 1; k <= t; k++)
            if (apat[k]) ab = 1'b1;
         last_w = t;
         t++;
         n++;
      end
      dc = t;
   endtask

   task automatic applyStimulus(input logic f, input logic [15:0] s, input logic [15:0] d,
                                input logic [15:0] l, input logic [7:0] fv);
      int dc;
      int wi;
      int ri;
      logic [15:0] ad;
      modelTransfer(f, s, d, l, fv, dc);
      for (int k = dc + 1; k < 1024; k++) spat[k] = 1'b0;
      wi = 0;
      ri = 0;
      obs_done = -1;
      @(posedge clk);
      #1;
      fill = f; src = s; dst = d; len = l; fill_val = fv;
      start = 1'b1; abort = 1'b0; grant = 1'b1;
      for (int c = 1; c <= dc + 1; c++) begin
         @(posedge clk);
         #1;
         grant = gpat[c];
         abort = apat[c];
         start = spat[c];
         if (spat[c]) begin
            src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
            fill = 1'($urandom); fill_val = 8'($urandom);
         end
         @(negedge clk);
         if (done && obs_done < 0) obs_done = c;
         checkOutput("busy", busy, c < dc);
         checkOutput("done", done, c == dc);
         if (!grant) checkOutput("enable while not granted", mem_enable, 1'b0);
         if (!mem_we) checkOutput("di while not writing", mem_di, 8'h00);
         if (mem_enable && mem_we) begin
            if (wi < exp_wa.size()) begin
               checkOutput("write address", mem_a, exp_wa[wi]);
               checkOutput("write data", mem_di, exp_wd[wi]);
            end else begin
               checkOutput("unexpected write", 1'b1, 1'b0);
            end
            wi++;
         end else if (mem_enable) begin
            if (ri < exp_ra.size())
               checkOutput("read address", mem_a, exp_ra[ri]);
            else
               checkOutput("unexpected read", 1'b1, 1'b0);
            ri++;
         end
      end
      checkOutput("write count", wi, exp_wa.size());
      checkOutput("read count", ri, exp_ra.size());
      for (int i = 0; i <= int'(l) + 1 && i < 12; i++) begin
         ad = d + 16'(i);
         checkOutput("memory image", ram[ad], ref_mem[ad]);
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      logic        rf;
      logic [15:0] rs;
      logic [15:0] rd;
      logic [15:0] rl;
      n_vec = 0;
      n_err = 0;
      reset = 1'b0; start = 1'b0; fill = 1'b0; src = '0; dst = '0; len = '0;
      fill_val = '0; abort = 1'b0; grant = 1'b1;
      pre_we = 1'b0; pre_a = '0; pre_d = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset enable", mem_enable, 1'b0);
      checkOutput("reset we", mem_we, 1'b0);
      checkOutput("reset addr", mem_a, 16'h0000);
      checkOutput("reset di", mem_di, 8'h00);
      reset = 1'b1;

      $display("[TB] fill 0x0400 x4");
      clearPatterns();
      applyStimulus(1'b1, 16'h0000, 16'h0400, 16'd4, 8'h20);
      checkOutput("fill done cycle", obs_done, 5);
      for (int i = 0; i < 4; i++)
         checkOutput("fill word", ram[16'h0400 + 16'(i)], 8'h20);

      $display("[TB] copy 0x1000 -> 0x2000 x3");
      preload(16'h1000, 8'h11);
      preload(16'h1001, 8'h22);
      preload(16'h1002, 8'h33);
      applyStimulus(1'b0, 16'h1000, 16'h2000, 16'd3, 8'h00);
      checkOutput("copy done cycle", obs_done, 10);
      checkOutput("copy word0", ram[16'h2000], 8'h11);
      checkOutput("copy word1", ram[16'h2001], 8'h22);
      checkOutput("copy word2", ram[16'h2002], 8'h33);

      $display("[TB] copy with grant stalls");
      gpat[1] = 1'b0;
      gpat[2] = 1'b0;
      gpat[8] = 1'b0;
      applyStimulus(1'b0, 16'h1000, 16'h2100, 16'd2, 8'h00);
      checkOutput("stall done cycle", obs_done, 10);
      checkOutput("stall word0", ram[16'h2100], 8'h11);
      checkOutput("stall word1", ram[16'h2101], 8'h22);

      $display("[TB] fill across address wrap");
      clearPatterns();
      applyStimulus(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h5A);
      checkOutput("wrap FFFE", ram[16'hFFFE], 8'h5A);
      checkOutput("wrap FFFF", ram[16'hFFFF], 8'h5A);
      checkOutput("wrap 0000", ram[16'h0000], 8'h5A);
      checkOutput("wrap 0001", ram[16'h0001], 8'h5A);

      $display("[TB] overlapping forward copy");
      preload(16'h3000, 8'hAA);
      applyStimulus(1'b0, 16'h3000, 16'h3001, 16'd3, 8'h00);
      for (int i = 1; i <= 3; i++)
         checkOutput("overlap word", ram[16'h3000 + 16'(i)], 8'hAA);

      $display("[TB] abort and ignored start");
      clearPatterns();
      apat[3] = 1'b1;
      spat[2] = 1'b1;
      applyStimulus(1'b1, 16'h0000, 16'h4000, 16'd10, 8'h77);
      checkOutput("abort done cycle", obs_done, 4);

      $display("[TB] zero length");
      clearPatterns();
      applyStimulus(1'b0, 16'h1000, 16'h4100, 16'd0, 8'h00);
      checkOutput("zero-length done cycle", obs_done, 1);

      $display("[TB] randomized transfers");
      for (int it = 0; it < 40; it++) begin
         rf = 1'($urandom_range(0, 1));
         rl = 16'($urandom_range(0, 8));
         rs = 16'($urandom);
         rd = ($urandom_range(0, 1) == 0) ? rs + 16'($urandom_range(0, 3)) : 16'($urandom);
         if (!rf)
            for (int i = 0; i < int'(rl); i++) preload(rs + 16'(i), 8'($urandom));
         randomPatterns();
         applyStimulus(rf, rs, rd, rl, 8'($urandom));
      end

      $display("[TB] reset during copy");
      clearPatterns();
      @(posedge clk);
      #1;
      fill = 1'b0; src = 16'h1000; dst = 16'h5000; len = 16'd3; start = 1'b1; grant = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         reset = (c != 5);
         @(negedge clk);
         if (c < 5) checkOutput("busy before reset", busy, 1'b1);
         if (c == 5) checkOutput("we during reset", mem_we, 1'b0);
         if (c > 5) begin
            checkOutput("busy after reset", busy, 1'b0);
            checkOutput("done after reset", done, 1'b0);
         end
      end

      $display("[TB] reset during fill write");
      preload(16'h6002, 8'h00);
      @(posedge clk);
      #1;
      fill = 1'b1; dst = 16'h6000; len = 16'd10; fill_val = 8'hC3; start = 1'b1; grant = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         reset = (c != 3);
         @(negedge clk);
         if (c == 3) begin
            checkOutput("we during reset", mem_we, 1'b0);
            checkOutput("enable during reset", mem_enable, 1'b0);
         end
         if (c > 3) begin
            checkOutput("busy after reset", busy, 1'b0);
            checkOutput("done after reset", done, 1'b0);
         end
      end
      checkOutput("fill before reset 0", ram[16'h6000], 8'hC3);
      checkOutput("fill before reset 1", ram[16'h6001], 8'hC3);
      checkOutput("no write at reset", ram[16'h6002], 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
